// File: rtl/vit_pkg.sv
// vit_pkg: shared constants and helpers for the (2,1,3) hard-decision Viterbi
// decoder.
//   N_STATES  trellis states (2^(K-1))
//   K         constraint length
//   G1, G0    generator polynomials, MSB = current input bit
//   exp_sym   encoder output for a given state and input bit, {V1,V0}
//   hamming2  Hamming distance between two 2-bit symbols (0..2)
package vit_pkg;

  localparam int N_STATES = 8;
  localparam int K        = 4;

  localparam logic [3:0] G1 = 4'b1011;
  localparam logic [3:0] G0 = 4'b1111;

  // The encoder register is {u, s[2], s[1], s[0]}; each output bit is the
  // parity of the taps selected by its generator.
  function automatic logic [1:0] exp_sym(input logic [2:0] state, input logic u);
    logic [3:0] taps;
    taps = {u, state};
    return {^(taps & G1), ^(taps & G0)};
  endfunction

  function automatic logic [1:0] hamming2(input logic [1:0] a, input logic [1:0] b);
    logic [1:0] x;
    x = a ^ b;
    return {1'b0, x[1]} + {1'b0, x[0]};
  endfunction

endpackage

// File: rtl/vit_acs.sv
// vit_acs: one add-compare-select unit.
//   pm0_i / pm1_i  metrics of the predecessors ending in 0 and in 1
//   bm0_i / bm1_i  branch metrics of the two incoming transitions
//   pm_o           selected candidate, one bit wider than the metrics so the
//                  caller can normalise and saturate without wrapping
//   dec_o          1 when the predecessor ending in 1 was chosen
module vit_acs #(
  parameter int PM_W = 6
) (
  input  logic [PM_W-1:0] pm0_i,
  input  logic [PM_W-1:0] pm1_i,
  input  logic [1:0]      bm0_i,
  input  logic [1:0]      bm1_i,
  output logic [PM_W:0]   pm_o,
  output logic            dec_o
);

  logic [PM_W:0] cand0;
  logic [PM_W:0] cand1;

  assign cand0 = {1'b0, pm0_i} + {{(PM_W-1){1'b0}}, bm0_i};
  assign cand1 = {1'b0, pm1_i} + {{(PM_W-1){1'b0}}, bm1_i};

  // Strict compare: a tie keeps the predecessor ending in 0.
  assign dec_o = (cand1 < cand0);
  assign pm_o  = dec_o ? cand1 : cand0;

endmodule

// File: rtl/vit_dec.sv
// vit_dec: hard-decision Viterbi decoder, 8 states, register-exchange
// survivors, fixed decision delay of TB_DEPTH symbols.
//   clock      rising-edge clock
//   reset      asynchronous active-low reset
//   start      synchronous frame start: re-initialise trellis to state 0
//   in_valid   Vy is accepted on this edge (no backpressure, may stay high)
//   Vy         received symbol {V1,V0}
//   out_valid  one-cycle pulse: Ux_hat holds a new decision
//   Ux_hat     decoded information bit
//   best_pm    minimum path metric after the last accepted symbol
//
// Handshake: a symbol is consumed on every rising edge where in_valid is 1;
// out_valid is a registered pulse that is high only in the cycle after an
// accepting edge that produced a decision, and is 0 after every idle edge.
module vit_dec #(
  parameter int TB_DEPTH = 15,
  parameter int PM_W     = 6
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            start,
  input  logic            in_valid,
  input  logic [1:0]      Vy,
  output logic            out_valid,
  output logic            Ux_hat,
  output logic [PM_W-1:0] best_pm
);

  import vit_pkg::*;

  localparam int               CNT_W    = $clog2(TB_DEPTH + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(TB_DEPTH);
  localparam logic [PM_W-1:0]  PM_MAX   = {PM_W{1'b1}};

  logic [PM_W-1:0]     pm_q     [N_STATES];
  logic [PM_W-1:0]     pm_cur   [N_STATES];
  logic [PM_W-1:0]     pm_d     [N_STATES];
  logic [TB_DEPTH-1:0] surv_q   [N_STATES];
  logic [TB_DEPTH-1:0] surv_cur [N_STATES];
  logic [TB_DEPTH-1:0] surv_d   [N_STATES];
  logic [PM_W:0]       cand     [N_STATES];
  logic [N_STATES-1:0] dec;
  logic [CNT_W-1:0]    cnt_q;
  logic [CNT_W-1:0]    cnt_cur;
  logic [PM_W-1:0]     min_q;
  logic [PM_W-1:0]     min_cur;
  logic [2:0]          best_q;
  logic                out_valid_q;
  logic                ux_q;

  // Best state over the registered metrics; ties go to the lowest index.
  always_comb begin
    min_q  = pm_q[0];
    best_q = 3'd0;
    for (int s = 1; s < N_STATES; s++) begin
      if (pm_q[s] < min_q) begin
        min_q  = pm_q[s];
        best_q = 3'(s);
      end
    end
  end

  // start overrides the registered trellis so a symbol accepted in the same
  // cycle is processed as symbol 0 from the known initial state.
  always_comb begin
    for (int s = 0; s < N_STATES; s++) begin
      if (start) begin
        pm_cur[s]   = (s == 0) ? '0 : PM_MAX;
        surv_cur[s] = '0;
      end else begin
        pm_cur[s]   = pm_q[s];
        surv_cur[s] = surv_q[s];
      end
    end
    cnt_cur = start ? '0 : cnt_q;
    min_cur = start ? '0 : min_q;
  end

  for (genvar ns = 0; ns < N_STATES; ns++) begin : g_acs
    localparam logic [2:0] NS = 3'(ns);
    localparam logic [2:0] P0 = {NS[1:0], 1'b0};
    localparam logic [2:0] P1 = {NS[1:0], 1'b1};

    logic [1:0]    bm0;
    logic [1:0]    bm1;
    logic [PM_W:0] norm;
    logic [2:0]    pred;

    // The input bit that leads into ns is ns[2].
    assign bm0 = hamming2(Vy, exp_sym(P0, NS[2]));
    assign bm1 = hamming2(Vy, exp_sym(P1, NS[2]));

    vit_acs #(.PM_W(PM_W)) u_acs (
      .pm0_i (pm_cur[P0]),
      .pm1_i (pm_cur[P1]),
      .bm0_i (bm0),
      .bm1_i (bm1),
      .pm_o  (cand[ns]),
      .dec_o (dec[ns])
    );

    // Every candidate is at least the old minimum, so the subtraction never
    // underflows; the saturation keeps unreachable states pinned at PM_MAX.
    assign norm     = cand[ns] - {1'b0, min_cur};
    assign pm_d[ns] = (norm > {1'b0, PM_MAX}) ? PM_MAX : norm[PM_W-1:0];

    assign pred       = {NS[1:0], dec[ns]};
    assign surv_d[ns] = {surv_cur[pred][TB_DEPTH-2:0], NS[2]};
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int s = 0; s < N_STATES; s++) begin
        pm_q[s]   <= (s == 0) ? '0 : PM_MAX;
        surv_q[s] <= '0;
      end
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      ux_q        <= 1'b0;
    end else begin
      out_valid_q <= 1'b0;
      if (in_valid) begin
        pm_q   <= pm_d;
        surv_q <= surv_d;
        // cnt_cur is only full when start is low, so the decision reads the
        // pre-update survivors of the current frame.
        if (cnt_cur == CNT_FULL) begin
          out_valid_q <= 1'b1;
          ux_q        <= surv_q[best_q][TB_DEPTH-1];
          cnt_q       <= cnt_cur;
        end else begin
          cnt_q <= cnt_cur + 1'b1;
        end
      end else if (start) begin
        pm_q   <= pm_cur;
        surv_q <= surv_cur;
        cnt_q  <= '0;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign Ux_hat    = ux_q;
  assign best_pm   = min_q;

endmodule

// File: tb/tb_vit_dec.sv
module tb_vit_dec;

  localparam int TB_DEPTH = 15;
  localparam int PM_W     = 6;

  // ---------------- clock / reset / DUTs ----------------
  logic            clock = 1'b0;
  logic            reset;
  logic            start;
  logic            in_valid;
  logic [1:0]      Vy;
  logic            out_valid;
  logic            Ux_hat;
  logic [PM_W-1:0] best_pm;
  logic            out_valid4;
  logic            Ux_hat4;
  logic [3:0]      best_pm4;

  int checks   = 0;
  int failures = 0;

  logic [0:0]  exp_q[$];
  logic [2:0]  enc_s = 3'b000;
  logic [39:0] pat   = 40'hB53C9E17A2;

  always #5 clock = ~clock;

  vit_dec #(.TB_DEPTH(TB_DEPTH), .PM_W(PM_W)) dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .in_valid  (in_valid),
    .Vy        (Vy),
    .out_valid (out_valid),
    .Ux_hat    (Ux_hat),
    .best_pm   (best_pm)
  );

  // Narrow-metric instance for the saturation scenario.
  vit_dec #(.TB_DEPTH(TB_DEPTH), .PM_W(4)) dut4 (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .in_valid  (in_valid),
    .Vy        (Vy),
    .out_valid (out_valid4),
    .Ux_hat    (Ux_hat4),
    .best_pm   (best_pm4)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  // Inputs change 1 time unit after the rising edge; outputs are sampled
  // 1 time unit after the edge that follows.
  task automatic step(input logic v, input logic st, input logic [1:0] sym);
    in_valid = v;
    start    = st;
    Vy       = sym;
    @(posedge clock);
    #1;
  endtask

  task automatic start_pulse();
    enc_s = 3'b000;
    exp_q.delete();
    step(1'b0, 1'b1, 2'b00);
  endtask

  // Encodes one information bit with the reference encoder and sends it.
  task automatic feed_bit(input logic u, input logic st);
    logic [1:0] sym;
    if (st) begin
      enc_s = 3'b000;
      exp_q.delete();
    end
    sym[1] = u ^ enc_s[1] ^ enc_s[0];
    sym[0] = u ^ enc_s[2] ^ enc_s[1] ^ enc_s[0];
    enc_s  = {u, enc_s[2:1]};
    exp_q.push_back(u);
    step(1'b1, st, sym);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    checks++;
    if (Ux_hat !== 1'b0) begin failures++; $display("FAIL reset_ux_hat: got %b want 0", Ux_hat); end
    checks++;
    if (best_pm !== '0) begin failures++; $display("FAIL reset_best_pm: got %0d want 0", best_pm); end
    checks++;
    if (best_pm4 !== 4'd0) begin failures++; $display("FAIL reset_best_pm4: got %0d want 0", best_pm4); end
  endtask

  // Hand-encoded info bits 1,0,1,1 followed by zeros.
  task automatic test_clean(input logic with_error);
    logic [1:0] syms [19];
    logic       exp_bits [4];
    logic       ev;
    logic [PM_W-1:0] epm;
    syms = '{2'b11, 2'b01, 2'b00, 2'b01, 2'b10, 2'b00, 2'b11,
             2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00,
             2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
    exp_bits = '{1'b1, 1'b0, 1'b1, 1'b1};
    if (with_error) syms[2] = 2'b10;
    start_pulse();
    for (int i = 0; i < 19; i++) begin
      step(1'b1, 1'b0, syms[i]);
      ev = (i >= TB_DEPTH);
      checks++;
      if (out_valid !== ev) begin
        failures++; $display("FAIL clean_out_valid[%0d] err=%0d: got %b want %b", i, with_error, out_valid, ev);
      end
      if (i >= TB_DEPTH) begin
        checks++;
        if (Ux_hat !== exp_bits[i-TB_DEPTH]) begin
          failures++; $display("FAIL clean_bit[%0d] err=%0d: got %b want %b", i-TB_DEPTH, with_error, Ux_hat, exp_bits[i-TB_DEPTH]);
        end
      end
      // best_pm is relative to the previous minimum: the error raises the
      // best path metric from 0 to 1 on symbol 2 only, afterwards it stays.
      epm = (with_error && i == 2) ? PM_W'(1) : '0;
      checks++;
      if (best_pm !== epm) begin
        failures++; $display("FAIL clean_best_pm[%0d] err=%0d: got %0d want %0d", i, with_error, best_pm, epm);
      end
    end
    step(1'b0, 1'b0, 2'b00);
  endtask

  task automatic test_latency_count();
    int   pulses;
    logic ev;
    logic [0:0] e;
    pulses = 0;
    start_pulse();
    for (int i = 0; i < 40; i++) begin
      feed_bit(pat[i], 1'b0);
      ev = (i >= TB_DEPTH);
      checks++;
      if (out_valid !== ev) begin failures++; $display("FAIL lat_out_valid[%0d]: got %b want %b", i, out_valid, ev); end
      if (out_valid === 1'b1) begin
        pulses++;
        e = exp_q.pop_front();
        checks++;
        if (Ux_hat !== e[0]) begin failures++; $display("FAIL lat_bit[%0d]: got %b want %b", i-TB_DEPTH, Ux_hat, e[0]); end
      end
    end
    step(1'b0, 1'b0, 2'b00);
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL lat_idle_out_valid: got %b want 0", out_valid); end
    checks++;
    if (pulses != 40 - TB_DEPTH) begin failures++; $display("FAIL lat_pulse_count: got %0d want %0d", pulses, 40 - TB_DEPTH); end
  endtask

  task automatic test_gapped();
    int   acc;
    int   cyc;
    int   pulses;
    logic v;
    logic ev;
    logic [0:0] e;
    acc = 0; cyc = 0; pulses = 0;
    start_pulse();
    while (acc < 40 && cyc < 400) begin
      v = 1'($urandom_range(0, 1));
      if (v) begin
        feed_bit(pat[acc], 1'b0);
        acc++;
        ev = (acc - 1 >= TB_DEPTH);
      end else begin
        step(1'b0, 1'b0, 2'($urandom_range(0, 3)));
        ev = 1'b0;
      end
      cyc++;
      checks++;
      if (out_valid !== ev) begin failures++; $display("FAIL gap_out_valid[cyc %0d]: got %b want %b", cyc, out_valid, ev); end
      if (out_valid === 1'b1 && exp_q.size() > 0) begin
        pulses++;
        e = exp_q.pop_front();
        checks++;
        if (Ux_hat !== e[0]) begin failures++; $display("FAIL gap_bit[%0d]: got %b want %b", pulses - 1, Ux_hat, e[0]); end
      end
    end
    checks++;
    if (acc != 40) begin failures++; $display("FAIL gap_accepted: got %0d want 40", acc); end
    checks++;
    if (pulses != 40 - TB_DEPTH) begin failures++; $display("FAIL gap_pulse_count: got %0d want %0d", pulses, 40 - TB_DEPTH); end
  endtask

  task automatic test_restart();
    int   pulses;
    logic ev;
    logic [0:0] e;
    start_pulse();
    for (int i = 0; i < 20; i++) begin
      feed_bit(pat[i], 1'b0);
      if (out_valid === 1'b1) begin
        e = exp_q.pop_front();
        checks++;
        if (Ux_hat !== e[0]) begin failures++; $display("FAIL rst1_bit[%0d]: got %b want %b", i-TB_DEPTH, Ux_hat, e[0]); end
      end
    end
    // New frame: its first symbol arrives together with start.
    pulses = 0;
    for (int j = 0; j < 30; j++) begin
      feed_bit(pat[39-j], (j == 0));
      ev = (j >= TB_DEPTH);
      checks++;
      if (out_valid !== ev) begin failures++; $display("FAIL restart_out_valid[%0d]: got %b want %b", j, out_valid, ev); end
      if (out_valid === 1'b1) begin
        pulses++;
        e = exp_q.pop_front();
        checks++;
        if (Ux_hat !== e[0]) begin failures++; $display("FAIL restart_bit[%0d]: got %b want %b", j-TB_DEPTH, Ux_hat, e[0]); end
      end
    end
    checks++;
    if (pulses != 30 - TB_DEPTH) begin failures++; $display("FAIL restart_pulse_count: got %0d want %0d", pulses, 30 - TB_DEPTH); end
    step(1'b0, 1'b0, 2'b00);
  endtask

  task automatic test_async_reset();
    logic ev;
    logic [0:0] e;
    start_pulse();
    for (int i = 0; i < 17; i++) begin
      feed_bit(pat[i], 1'b0);
      if (out_valid === 1'b1) begin
        e = exp_q.pop_front();
        checks++;
        if (Ux_hat !== e[0]) begin failures++; $display("FAIL ares_pre_bit[%0d]: got %b want %b", i-TB_DEPTH, Ux_hat, e[0]); end
      end
    end
    // The last decision was info bit 1 (=1), so both outputs are high here.
    checks++;
    if (out_valid !== 1'b1 || Ux_hat !== 1'b1) begin
      failures++; $display("FAIL ares_pre_outputs: got %b%b want 11", out_valid, Ux_hat);
    end
    in_valid = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL ares_out_valid: got %b want 0", out_valid); end
    checks++;
    if (Ux_hat !== 1'b0) begin failures++; $display("FAIL ares_ux_hat: got %b want 0", Ux_hat); end
    checks++;
    if (best_pm !== '0) begin failures++; $display("FAIL ares_best_pm: got %0d want 0", best_pm); end
    @(posedge clock);
    #1;
    reset = 1'b1;
    enc_s = 3'b000;
    exp_q.delete();
    for (int j = 0; j < 20; j++) begin
      feed_bit(pat[20+j], 1'b0);
      ev = (j >= TB_DEPTH);
      checks++;
      if (out_valid !== ev) begin failures++; $display("FAIL ares_post_out_valid[%0d]: got %b want %b", j, out_valid, ev); end
      if (out_valid === 1'b1) begin
        e = exp_q.pop_front();
        checks++;
        if (Ux_hat !== e[0]) begin failures++; $display("FAIL ares_post_bit[%0d]: got %b want %b", j-TB_DEPTH, Ux_hat, e[0]); end
      end
    end
    step(1'b0, 1'b0, 2'b00);
  endtask

  task automatic test_saturation();
    logic ev;
    start_pulse();
    for (int i = 0; i < 100; i++) begin
      step(1'b1, 1'b0, (i % 2 == 0) ? 2'b11 : 2'b10);
      ev = (i >= TB_DEPTH);
      checks++;
      if ($isunknown({out_valid4, Ux_hat4, best_pm4})) begin
        failures++; $display("FAIL sat_x[%0d]: got %b%b%b want no X", i, out_valid4, Ux_hat4, best_pm4);
      end
      checks++;
      if (best_pm4 > 4'd2) begin failures++; $display("FAIL sat_min_pm4[%0d]: got %0d want <=2", i, best_pm4); end
      checks++;
      if (best_pm > PM_W'(2)) begin failures++; $display("FAIL sat_min_pm6[%0d]: got %0d want <=2", i, best_pm); end
      checks++;
      if (out_valid4 !== ev) begin failures++; $display("FAIL sat_out_valid[%0d]: got %b want %b", i, out_valid4, ev); end
    end
    step(1'b0, 1'b0, 2'b00);
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    reset    = 1'b0;
    start    = 1'b0;
    in_valid = 1'b0;
    Vy       = 2'b00;
    #12;
    test_reset();
    @(posedge clock);
    #1;
    reset = 1'b1;
    step(1'b0, 1'b0, 2'b00);
    test_reset();
    test_clean(1'b0);
    test_clean(1'b1);
    test_latency_count();
    test_gapped();
    test_restart();
    test_async_reset();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
